// File: rtl/fb_write_scheduler.sv
// Frame buffer write scheduler: owns the single BRAM write port and arbitrates
// GB pixel capture > host writes > background clear, one registered write/cycle.
//
// Ports:
//   clk, reset        : system clock, async active-high reset
//   clear_start       : pulse, start/restart a full clear
//   clear_busy        : clear engine active
//   gb_vs/cpl/valid   : GB vsync, pixel latch, pixel valid
//   gb_pixel          : GB 2-bit pixel
//   host_req/addr/    : host write request (level), linear address, data
//   host_wdata
//   host_ack          : one-cycle host acknowledge
//   mem_we/addr/wdata : frame buffer write port (linear y*WIDTH+x)
//   frame_done        : pulse with the write of the last pixel of a frame
module fb_write_scheduler #(
  parameter int          WIDTH  = 160,
  parameter int          HEIGHT = 144,
  parameter int          ADDR_W = 15,
  parameter logic [1:0]  FILL   = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              gb_vs,
  input  logic              gb_cpl,
  input  logic              gb_valid,
  input  logic [1:0]        gb_pixel,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [1:0]        host_wdata,
  output logic              host_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  output logic              frame_done
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int TOTAL = WIDTH * HEIGHT;

  localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] A_SIZE = ADDR_W'(TOTAL);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_t;

  // capture path
  logic              r_prev;
  logic              r_vs_d;
  logic [XW-1:0]     r_cap_x;
  logic [YW-1:0]     r_cap_y;
  logic [ADDR_W-1:0] r_cap_addr;
  logic              r_pend;
  logic [1:0]        r_pend_data;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_pend_last;

  // clear engine
  clr_state_t        r_state;
  clr_state_t        w_state_nx;
  logic [ADDR_W-1:0] r_clear_ptr;
  logic [ADDR_W-1:0] w_ptr_nx;
  logic              w_clr_we;

  logic              w_vc;
  logic              w_strobe;
  logic              w_vs_rise;
  logic [XW-1:0]     w_base_x;
  logic [YW-1:0]     w_base_y;
  logic [ADDR_W-1:0] w_base_addr;
  logic              w_x_end;
  logic              w_y_end;

  assign w_vc      = gb_valid & gb_cpl;
  assign w_strobe  = w_vc & ~r_prev;
  assign w_vs_rise = gb_vs & ~r_vs_d;

  // vsync realigns before a coincident strobe is captured
  assign w_base_x    = w_vs_rise ? '0 : r_cap_x;
  assign w_base_y    = w_vs_rise ? '0 : r_cap_y;
  assign w_base_addr = w_vs_rise ? '0 : r_cap_addr;
  assign w_x_end     = (w_base_x == X_LAST);
  assign w_y_end     = (w_base_y == Y_LAST);

  assign clear_busy = (r_state == S_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_cap_x     <= '0;
      r_cap_y     <= '0;
      r_cap_addr  <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= 2'd0;
      r_pend_addr <= '0;
      r_pend_last <= 1'b0;
    end else begin
      r_prev <= w_vc;
      r_vs_d <= gb_vs;
      // pending always drains the next edge; strobes are >= 2 cycles apart
      r_pend <= w_strobe;
      if (w_strobe) begin
        r_pend_data <= gb_pixel;
        r_pend_addr <= w_base_addr;
        r_pend_last <= w_x_end & w_y_end;
        r_cap_x     <= w_x_end ? '0 : w_base_x + 1'b1;
        if (w_x_end) begin
          r_cap_y <= w_y_end ? '0 : w_base_y + 1'b1;
        end else begin
          r_cap_y <= w_base_y;
        end
        if (w_x_end & w_y_end) begin
          r_cap_addr <= '0;
        end else begin
          r_cap_addr <= w_base_addr + 1'b1;
        end
      end else if (w_vs_rise) begin
        r_cap_x    <= '0;
        r_cap_y    <= '0;
        r_cap_addr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_clear_ptr <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_clear_ptr <= w_ptr_nx;
    end
  end

  // clear only gets the port when neither pixel nor host claims it;
  // a restart pulse drops that cycle's clear grant
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_clear_ptr;
    w_clr_we   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          w_state_nx = S_CLEAR;
          w_ptr_nx   = '0;
        end
      end
      S_CLEAR: begin
        if (clear_start) begin
          w_ptr_nx = '0;
        end else if (!r_pend && !host_req) begin
          w_clr_we = 1'b1;
          w_ptr_nx = r_clear_ptr + 1'b1;
          if (r_clear_ptr == A_LAST) begin
            w_state_nx = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 2'd0;
      host_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      host_ack   <= 1'b0;
      frame_done <= 1'b0;
      if (r_pend) begin
        mem_we     <= 1'b1;
        mem_addr   <= r_pend_addr;
        mem_wdata  <= r_pend_data;
        frame_done <= r_pend_last;
      end else if (host_req) begin
        host_ack <= 1'b1;
        // out-of-range host writes are acked and dropped
        if (host_addr < A_SIZE) begin
          mem_we    <= 1'b1;
          mem_addr  <= host_addr;
          mem_wdata <= host_wdata;
        end
      end else if (w_clr_we) begin
        mem_we    <= 1'b1;
        mem_addr  <= r_clear_ptr;
        mem_wdata <= FILL;
      end
    end
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single write port of the 160x144 2-bit Game Boy frame buffer.
- Arbitrates three write sources:
  - Game Boy pixel capture, driven by edge-detected valid/cpl with x/y counters and vsync realignment.
  - An external host writer using a req/ack handshake (OSD/debug snapshot restore).
  - A background clear engine that fills the buffer with a constant value.
- Sits between the Game Boy core and the frame buffer BRAM in the clk domain. It replaces ad-hoc init/capture logic and uses linear addressing (y*WIDTH+x).

Parameters:
WIDTH, 160, pixels per line
HEIGHT, 144, lines per frame
ADDR_W, 15, frame buffer address width (WIDTH*HEIGHT <= 2**ADDR_W)
FILL, 2'd0, value written by clear engine

Ports:
clk  in  1  Game Boy system clock
reset  in  1  asynchronous, active-high reset
clear_start  in  1  one-cycle pulse, start/restart clear
clear_busy  out  1  clear engine active
gb_vs  in  1  Game Boy vertical sync
gb_cpl  in  1  Game Boy pixel latch
gb_valid  in  1  Game Boy pixel valid
gb_pixel  in  2  Game Boy pixel data
host_req  in  1  host write request (level)
host_addr  in  ADDR_W  host linear write address
host_wdata  in  2  host write data
host_ack  out  1  one-cycle host write acknowledge
mem_we  out  1  frame buffer write enable
mem_addr  out  ADDR_W  frame buffer linear address
mem_wdata  out  2  frame buffer write data
frame_done  out  1  one-cycle pulse, last pixel of frame written

Behaviour:
- Reset (async assert, sync release):
  - mem_we, mem_addr, mem_wdata, host_ack, frame_done = 0.
  - Capture counters (cap_x, cap_y, cap_addr) = 0; edge registers = 0; pixel pending = 0.
  - Clear FSM state = CLEAR with clear_ptr = 0, so clear_busy = 1 during and after reset. Every reset, including mid-operation, restarts a full clear.
- Pixel strobe:
  - strobe = (gb_valid & gb_cpl) & ~prev, where prev is the registered (gb_valid & gb_cpl).
  - Strobes are therefore at least 2 cycles apart.
- Capture:
  - On a strobe edge, pending <= 1, pend_data <= gb_pixel, pend_addr <= cap_addr.
  - Counters advance: cap_x+1 and cap_addr+1. When cap_x == WIDTH-1: cap_x <= 0, cap_y+1.
  - When cap_x == WIDTH-1 and cap_y == HEIGHT-1: all counters wrap to 0 and the pending entry is tagged last.
- vsync:
  - A rising edge of gb_vs (registered edge detect) zeroes cap_x, cap_y and cap_addr.
  - If it coincides with a strobe, vsync applies first: the pixel is captured at addr 0 and the counters become 1/0/1.
- Arbitration, evaluated every clk edge, priority pixel > host > clear. Write outputs are registered, one write per cycle.
  - pending: mem_we <= 1, mem_addr <= pend_addr, mem_wdata <= pend_data, pending <= 0 (unless a new strobe sets it the same edge), frame_done <= last.
  - else host_req: host_ack <= 1 for one cycle.
    - If host_addr < WIDTH*HEIGHT: mem_we <= 1, mem_addr <= host_addr, mem_wdata <= host_wdata.
    - Otherwise mem_we <= 0 (the request is acked and dropped).
  - else state CLEAR: mem_we <= 1, mem_addr <= clear_ptr, mem_wdata <= FILL, clear_ptr+1. After writing WIDTH*HEIGHT-1, state <= IDLE.
  - else: mem_we <= 0.
  - host_ack and frame_done default to 0 every cycle.
- Latency:
  - Pixel: mem_we is high in the 2nd cycle after gb_valid&gb_cpl is first sampled high. The pending register always drains the next edge, so pixels are never lost.
- Host handshake:
  - host_req, host_addr and host_wdata are held stable until host_ack.
  - The host deasserts host_req in the ack cycle. If req is still high on the following edge, a second write is issued.
- Clear FSM (IDLE, CLEAR):
  - clear_start in IDLE: CLEAR, clear_ptr <= 0.
  - clear_start in CLEAR: clear_ptr <= 0 (restart); a grant on the same edge is discarded.
  - Clear stalls, without skipping addresses, whenever pixel or host wins.
  - Clear does not touch the capture counters. Captured pixels may later be overwritten by clear; this is accepted.

Test Plan:
- Reset release with no other traffic: exactly 23040 writes, FILL at addr 0..23039 in order; clear_busy falls the cycle after the addr 23039 write; no further mem_we.
- After clear, 23040 valid&cpl pulses (1 high, 1 low) with pixel=addr[1:0]: mem[k]=k%4; single frame_done coincident with the addr 23039 write; the next pulse writes addr 0.
- gb_vs rise after 500 pixels, then 3 pixels: they land at addr 0,1,2; vs rise on the same edge as a strobe writes that pixel to addr 0.
- Host req addr 100 data 3 during clear, alongside pixel strobes: pixel writes first, host_ack one cycle with the addr 100 write, clear resumes at the stalled ptr with no address skipped; host_addr 23040 gets acked with mem_we=0.
- clear_start while clear_ptr=5000: next clear write at addr 0; full 23040-address sweep follows.
- Async reset asserted mid-frame and mid-host-request: outputs 0 immediately; after release, clear restarts from 0; capture restarts at addr 0.
